ac_scan_ctrl: RTL and testbench
===============================

Name: ac_scan_ctrl

Overview:
Multi-cycle sequencer for the Aho-Corasick goto/failure tables. It accepts one input character per handshake and scans the goto table one entry per cycle. On a miss it follows failure links, then looks up the accept flag and emits the next state with a match flag. It sits between the byte stream source and the table RAMs and owns the current automaton state.

Parameters:
N_ENTRIES, 32, number of goto table entries scanned per lookup
SW, 8, state width (current/next/failure)
CW, 8, character width
AW, 5, goto table address width, clog2(N_ENTRIES)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
IN_VALID  in  1  character available
IN_READY  out  1  controller idle, can accept a character
IN_CHAR  in  CW  input character
TBL_RD  out  1  goto table read strobe
TBL_ADDR  out  AW  goto table entry index
TBL_CUR  in  SW  entry current-state field, valid the cycle after TBL_RD
TBL_CHR  in  CW  entry character field, same timing
TBL_NXT  in  SW  entry next-state field, same timing
FT_RD  out  1  failure/accept table read strobe
FT_ADDR  out  SW  state index (entry 0 = root)
FT_FAIL  in  SW  failure state of FT_ADDR, valid the cycle after FT_RD
FT_ACC  in  1  accept flag of FT_ADDR, same timing
OUT_VALID  out  1  one-cycle pulse: result for the last character
OUT_STATE  out  SW  state after this character
OUT_MATCH  out  1  OUT_STATE is accepting (qualified by OUT_VALID)
ERR  out  1  sticky: failure chain exceeded N_ENTRIES hops

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE, state register=0, hop counter=0, IN_READY=1, all strobes and OUT_* cleared to 0, ERR=0.
- FSM states: IDLE, SCAN, FREQ, FWAIT, AREQ, AWAIT, EMIT.
- IDLE: IN_READY=1. On IN_VALID=1, latch IN_CHAR, set hop=0, go to SCAN.
- SCAN: TBL_RD=1 with TBL_ADDR=idx, idx increments each cycle from 0. A delayed valid bit marks the response of idx-1.
  - Compare TBL_CUR==cur && TBL_CHR==char.
  - First hit: cur<=TBL_NXT, stop issuing reads, discard any in-flight response, go to AREQ.
  - Response for N_ENTRIES-1 with no hit, and cur==0: cur stays 0, go to EMIT with match=0; the root is never accepting.
  - Response for N_ENTRIES-1 with no hit, and cur!=0: go to FREQ.
- FREQ: FT_RD=1, FT_ADDR=cur, then FWAIT.
- FWAIT: cur<=FT_FAIL, hop++, re-enter SCAN with idx=0.
  - If hop reaches N_ENTRIES: set ERR, force cur=0, go to EMIT with match=0.
- AREQ/AWAIT: FT_RD=1 with FT_ADDR=cur, then capture FT_ACC as match, go to EMIT.
- EMIT: OUT_VALID=1 for exactly one cycle with OUT_STATE=cur and OUT_MATCH=match. Return to IDLE; IN_READY rises the following cycle.
- Latency from accept to OUT_VALID:
  - Hit on entry k from the first scan: k+5 cycles.
  - Each failure hop adds N_ENTRIES+3 cycles.
  - Root miss: N_ENTRIES+2 cycles.
- cur persists across characters and is the automaton state. It is cleared only by reset or by the ERR path.
- Duplicate goto entries: the lowest index wins.
- IN_VALID while busy is ignored, because IN_READY=0. The source must hold the character until the handshake.
- Reset mid-scan aborts the scan immediately; no OUT_VALID is produced for that character.
- FT_RD and TBL_RD are never asserted in the same cycle.

Decomposition:
- Package ac_pkg: SW, CW, AW, N_ENTRIES constants; FSM state enum; goto entry struct {cur, chr, nxt}.
- One sub-module, ac_goto_scan: index counter, read-valid pipe and comparator, with start/hit/done/nxt outputs. The FSM drives it.

Test Plan:
Tables use patterns he/she/his/hers:
- Goto: 0-h-1, 1-e-2, 2-r-8, 8-s-9, 1-i-6, 6-s-7, 0-s-3, 3-h-4, 4-e-5.
- Failure: f1..f9 = 0,0,0,1,2,0,3,0,3.
- Accept set: 2,5,7,9.

Scenarios:
- Stream "ushers" -> OUT_STATE 0,3,4,5,8,9; OUT_MATCH 0,0,0,1,0,1. The 'r' step shows one failure hop (5->2).
- Single 'x' from reset -> OUT_STATE=0, OUT_MATCH=0, latency N_ENTRIES+2, ERR=0.
- Hit on entry 0 ('h' from root) -> OUT_VALID exactly 5 cycles after the handshake; exactly one OUT_VALID pulse per character.
- IN_VALID held high continuously through "his" -> exactly 3 handshakes; outputs 1,6,7 with match on 7; IN_READY=0 during processing.
- Failure table with a cycle (f1=2, f2=1, no matching goto) from state 1 -> ERR=1 after N_ENTRIES hops, OUT_STATE=0.
- RST pulsed low during the SCAN for 's' -> no OUT_VALID; after release, IN_READY=1, cur=0; then "he" -> states 1,2 with match=1 on 2.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared constants, FSM encoding and goto-table entry layout for the
// Aho-Corasick scan controller.
package ac_pkg;

    localparam int unsigned N_ENTRIES = 32;
    localparam int unsigned SW        = 8;
    localparam int unsigned CW        = 8;
    localparam int unsigned AW        = 5;
    localparam int unsigned HW        = $clog2(N_ENTRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FREQ,
        S_FWAIT,
        S_AREQ,
        S_AWAIT,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic [SW-1:0] cur;
        logic [CW-1:0] chr;
        logic [SW-1:0] nxt;
    } goto_entry_t;

endpackage

// File: rtl/ac_goto_scan.sv
// Linear goto-table scanner: issues one read per cycle from entry 0 and
// compares each returning entry against (cur, chr); lowest hit wins.
module ac_goto_scan
    import ac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SW-1:0]     cur,
    input  logic [CW-1:0]     chr,
    input  goto_entry_t       entry,
    output logic              rd,
    output logic [AW-1:0]     addr,
    output logic              hit_c,
    output logic              done_c,
    output logic [SW-1:0]     nxt_c
);

    logic          issuing;
    logic          vld;
    logic          last;
    logic [AW-1:0] idx;
    logic          is_last_idx;

    assign is_last_idx = (idx == AW'(N_ENTRIES - 1));

    // vld marks that the entry bus carries the response to the previous read
    assign hit_c  = vld && (entry.cur == cur) && (entry.chr == chr);
    assign done_c = vld && last && !hit_c;
    assign nxt_c  = entry.nxt;
    assign rd     = issuing;
    assign addr   = idx;

    // A hit cancels further reads and drops the response already in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            issuing <= 1'b0;
            vld     <= 1'b0;
            last    <= 1'b0;
        end else if (start) begin
            idx     <= '0;
            issuing <= 1'b1;
            vld     <= 1'b0;
            last    <= 1'b0;
        end else if (hit_c) begin
            issuing <= 1'b0;
            vld     <= 1'b0;
            last    <= 1'b0;
        end else begin
            vld  <= issuing;
            last <= issuing && is_last_idx;
            if (issuing) begin
                idx     <= AW'(idx + AW'(1));
                issuing <= !is_last_idx;
            end
        end
    end

endmodule

// File: rtl/ac_scan_ctrl.sv
// Aho-Corasick character sequencer: goto scan, failure-link walk,
// accept lookup and one-cycle result pulse per accepted character.
module ac_scan_ctrl
    import ac_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_char,
    output logic          tbl_rd,
    output logic [AW-1:0] tbl_addr,
    input  logic [SW-1:0] tbl_cur,
    input  logic [CW-1:0] tbl_chr,
    input  logic [SW-1:0] tbl_nxt,
    output logic          ft_rd,
    output logic [SW-1:0] ft_addr,
    input  logic [SW-1:0] ft_fail,
    input  logic          ft_acc,
    output logic          out_valid,
    output logic [SW-1:0] out_state,
    output logic          out_match,
    output logic          err
);

    state_t        state, state_nxt;
    logic [SW-1:0] cur, cur_nxt;
    logic [CW-1:0] chr, chr_nxt;
    logic [HW-1:0] hop, hop_nxt, hop_inc;
    logic          match, match_nxt;
    logic          err_nxt;
    logic          scan_start_c;
    logic          hit_c, done_c;
    logic [SW-1:0] scan_nxt_c;
    goto_entry_t   entry;

    assign entry   = '{cur: tbl_cur, chr: tbl_chr, nxt: tbl_nxt};
    assign hop_inc = HW'(hop + HW'(1));
    assign ft_addr = cur;

    ac_goto_scan u_scan (
        .clk    (clk),
        .rst    (rst),
        .start  (scan_start_c),
        .cur    (cur),
        .chr    (chr),
        .entry  (entry),
        .rd     (tbl_rd),
        .addr   (tbl_addr),
        .hit_c  (hit_c),
        .done_c (done_c),
        .nxt_c  (scan_nxt_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            chr       <= '0;
            hop       <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            ft_rd     <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_match <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            chr       <= chr_nxt;
            hop       <= hop_nxt;
            match     <= match_nxt;
            err       <= err_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            ft_rd     <= (state_nxt == S_FREQ) || (state_nxt == S_AREQ);
            out_valid <= (state == S_EMIT);
            if (state == S_EMIT) begin
                out_state <= cur;
                out_match <= match;
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        chr_nxt      = chr;
        hop_nxt      = hop;
        match_nxt    = match;
        err_nxt      = err;
        scan_start_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    chr_nxt      = in_char;
                    hop_nxt      = '0;
                    scan_start_c = 1'b1;
                    state_nxt    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit_c) begin
                    cur_nxt   = scan_nxt_c;
                    state_nxt = S_AREQ;
                end else if (done_c) begin
                    if (cur == '0) begin
                        match_nxt = 1'b0;
                        state_nxt = S_EMIT;
                    end else begin
                        state_nxt = S_FREQ;
                    end
                end
            end
            S_FREQ: state_nxt = S_FWAIT;
            S_FWAIT: begin
                hop_nxt = hop_inc;
                // A runaway failure chain falls back to the root
                if (hop_inc == HW'(N_ENTRIES)) begin
                    err_nxt   = 1'b1;
                    cur_nxt   = '0;
                    match_nxt = 1'b0;
                    state_nxt = S_EMIT;
                end else begin
                    cur_nxt      = ft_fail;
                    scan_start_c = 1'b1;
                    state_nxt    = S_SCAN;
                end
            end
            S_AREQ:  state_nxt = S_AWAIT;
            S_AWAIT: begin
                match_nxt = ft_acc;
                state_nxt = S_EMIT;
            end
            S_EMIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ac_scan_ctrl.sv
// Directed and random character streams against an abstract automaton model
// with table RAM models for the goto and failure/accept tables.
module tb_ac_scan_ctrl;
    import ac_pkg::*;

    localparam int NI = int'(N_ENTRIES);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_char;
    logic          tbl_rd;
    logic [AW-1:0] tbl_addr;
    logic [SW-1:0] tbl_cur;
    logic [CW-1:0] tbl_chr;
    logic [SW-1:0] tbl_nxt;
    logic          ft_rd;
    logic [SW-1:0] ft_addr;
    logic [SW-1:0] ft_fail;
    logic          ft_acc;
    logic          out_valid;
    logic [SW-1:0] out_state;
    logic          out_match;
    logic          err;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int hs = 0;
    int conflicts = 0;

    goto_entry_t   gtab [NI];
    logic [SW-1:0] ftab [256];
    logic          acc  [256];
    logic [SW-1:0] model_cur;
    bit            model_err;

    ac_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .tbl_rd    (tbl_rd),
        .tbl_addr  (tbl_addr),
        .tbl_cur   (tbl_cur),
        .tbl_chr   (tbl_chr),
        .tbl_nxt   (tbl_nxt),
        .ft_rd     (ft_rd),
        .ft_addr   (ft_addr),
        .ft_fail   (ft_fail),
        .ft_acc    (ft_acc),
        .out_valid (out_valid),
        .out_state (out_state),
        .out_match (out_match),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAMs; junk on the buses when not read
    always @(posedge clk) begin
        if (tbl_rd) {tbl_cur, tbl_chr, tbl_nxt} <= gtab[tbl_addr];
        else        {tbl_cur, tbl_chr, tbl_nxt} <= 24'($urandom);
        if (ft_rd) begin
            ft_fail <= ftab[ft_addr];
            ft_acc  <= acc[ft_addr];
        end else begin
            ft_fail <= 8'($urandom);
            ft_acc  <= 1'($urandom);
        end
        if (tbl_rd && ft_rd) conflicts <= conflicts + 1;
        if (rst && in_valid && in_ready) hs <= hs + 1;
    end

    always @(negedge clk) if (out_valid) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Abstract automaton step: goto lookup, failure walk, hop limit
    function automatic void model(input logic [SW-1:0] s0, input logic [CW-1:0] c,
                                  output logic [SW-1:0] ns, output logic nm,
                                  output bit ne, output int lat);
        logic [SW-1:0] s;
        int hops;
        int k;
        s = s0;
        hops = 0;
        ne = 0;
        ns = '0;
        nm = 1'b0;
        lat = 0;
        while (1) begin
            k = -1;
            for (int i = 0; i < NI; i++)
                if (k < 0 && gtab[i].cur == s && gtab[i].chr == c) k = i;
            if (k >= 0) begin
                ns = gtab[k].nxt;
                nm = acc[ns];
                lat = hops * (NI + 3) + k + 5;
                return;
            end
            if (s == 0) begin
                lat = hops * (NI + 3) + NI + 2;
                return;
            end
            s = ftab[s];
            hops++;
            if (hops == NI) begin
                ne = 1;
                lat = hops * (NI + 3) + 1;
                return;
            end
        end
    endfunction

    task automatic send(input logic [CW-1:0] c, input bit hold);
        logic [SW-1:0] es;
        logic em;
        bit ee, busy_ok, seen;
        int el, lat, wt;
        model(model_cur, c, es, em, ee, el);
        if (ee) model_err = 1;
        in_char = c;
        in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        check("in_ready_before_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        busy_ok = 1;
        seen = 0;
        while (!seen && lat < 2000) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            if (out_valid) seen = 1;
            else begin
                lat++;
                if (in_ready) busy_ok = 0;
            end
        end
        check("out_valid_seen", 32'(seen), 32'd1);
        check("out_state", 32'(out_state), 32'(es));
        check("out_match", 32'(out_match), 32'(em));
        check("latency", 32'(lat), 32'(el));
        check("err", 32'(err), 32'(model_err));
        check("in_ready_low_busy", 32'(busy_ok), 32'd1);
        model_cur = es;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_cur = '0;
        model_err = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, h0;
        string s;
        logic [CW-1:0] alphabet [7];

        for (int i = 0; i < NI; i++) gtab[i] = '{cur: 8'hFF, chr: 8'h00, nxt: 8'h00};
        gtab[0] = '{cur: 8'd0, chr: "h", nxt: 8'd1};
        gtab[1] = '{cur: 8'd1, chr: "e", nxt: 8'd2};
        gtab[2] = '{cur: 8'd2, chr: "r", nxt: 8'd8};
        gtab[3] = '{cur: 8'd8, chr: "s", nxt: 8'd9};
        gtab[4] = '{cur: 8'd1, chr: "i", nxt: 8'd6};
        gtab[5] = '{cur: 8'd6, chr: "s", nxt: 8'd7};
        gtab[6] = '{cur: 8'd0, chr: "s", nxt: 8'd3};
        gtab[7] = '{cur: 8'd3, chr: "h", nxt: 8'd4};
        gtab[8] = '{cur: 8'd4, chr: "e", nxt: 8'd5};
        gtab[20] = '{cur: 8'd0, chr: "h", nxt: 8'd5};   // shadowed duplicate
        for (int i = 0; i < 256; i++) begin
            ftab[i] = '0;
            acc[i] = 1'b0;
        end
        ftab[4] = 8'd1; ftab[5] = 8'd2; ftab[7] = 8'd3; ftab[9] = 8'd3;
        acc[2] = 1'b1; acc[5] = 1'b1; acc[7] = 1'b1; acc[9] = 1'b1;
        alphabet[0] = "h"; alphabet[1] = "e"; alphabet[2] = "r"; alphabet[3] = "s";
        alphabet[4] = "i"; alphabet[5] = "x"; alphabet[6] = "u";

        rst = 1'b0;
        in_valid = 1'b0;
        in_char = '0;
        model_cur = '0;
        model_err = 0;

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_tbl_rd", 32'(tbl_rd), 32'd0);
        check("rst_ft_rd", 32'(ft_rd), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_state", 32'(out_state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Root miss from reset
        send("x", 0);

        s = "ushers";
        for (int i = 0; i < s.len(); i++) send(s[i], 0);

        // Hit on entry 0, exactly one pulse
        apply_reset();
        p0 = pulses;
        send("h", 0);
        repeat (5) @(negedge clk);
        check("single_pulse", 32'(pulses - p0), 32'd1);

        // IN_VALID held high through "his"
        apply_reset();
        p0 = pulses;
        h0 = hs;
        send("h", 1);
        send("i", 1);
        send("s", 1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("held_handshakes", 32'(hs - h0), 32'd3);
        check("held_pulses", 32'(pulses - p0), 32'd3);

        // Reset in the middle of a scan
        apply_reset();
        p0 = pulses;
        in_char = "s";
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_tbl_rd", 32'(tbl_rd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_cur = '0;
        repeat (40) @(negedge clk);
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        send("h", 0);
        send("e", 0);

        // Random stream against the model
        for (int i = 0; i < 60; i++) send(alphabet[$urandom_range(0, 6)], 0);

        // Cyclic failure chain triggers the hop limit
        apply_reset();
        ftab[1] = 8'd2;
        ftab[2] = 8'd1;
        send("h", 0);
        send("x", 0);
        send("h", 0);
        ftab[1] = 8'd0;
        ftab[2] = 8'd0;
        apply_reset();
        @(negedge clk);
        check("err_cleared_by_rst", 32'(err), 32'd0);
        check("no_rd_conflict", 32'(conflicts), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
